// File: rtl/toggle_event_rx.sv
// ============================================================================
// Module   : toggle_event_rx
// Purpose  : Receive side of a toggle-encoded event link. Synchronizes tog_in,
//            queues each level change as a pending event, and hands events out
//            over valid/ready, toggling ack_tog once per consumed event.
// Options  : `TOGGLE_EVENT_RX_ERR_CLR_EN adds err_clr to clear the sticky
//            overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module toggle_event_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tog_in,
    input  logic             ev_ready,
`ifdef TOGGLE_EVENT_RX_ERR_CLR_EN
    input  logic             err_clr,
`endif
    output logic             ev_valid,
    output logic             ack_tog,
    output logic [CNT_W-1:0] pending,
    output logic             overflow
);

    localparam logic [0:0]       C_ST_INIT   = 1'b0;
    localparam logic [0:0]       C_ST_RUN    = 1'b1;
    localparam logic [2:0]       C_INIT_LAST = 3'(SYNC_STAGES);
    localparam logic [CNT_W-1:0] C_MAX       = '1;
    localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   edge_q,    edge_d;
    logic [0:0]             state_q,   state_d;
    logic [2:0]             init_cnt_q, init_cnt_d;
    logic [CNT_W-1:0]       pending_q, pending_d;
    logic                   valid_q,   valid_d;
    logic                   ack_q,     ack_d;
    logic                   ovf_q,     ovf_d;

    logic w_s;
    logic w_consume;
    logic w_ovf_set;
    logic w_ovf_clr;

    assign w_s       = sync_q[SYNC_STAGES-1];
    assign w_consume = valid_q & ev_ready;

`ifdef TOGGLE_EVENT_RX_ERR_CLR_EN
    assign w_ovf_clr = err_clr;
`else
    assign w_ovf_clr = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        pending_d  = pending_q;
        w_ovf_set  = 1'b0;

        // History keeps following s during INIT so a high line at release is not an event
        if (state_q == C_ST_INIT) begin
            init_cnt_d = init_cnt_q + 3'd1;
            if (init_cnt_q == C_INIT_LAST) begin
                state_d = C_ST_RUN;
            end
        end
        edge_d = (state_q == C_ST_RUN) & (w_s ^ hist_q);

        case ({edge_q, w_consume})
            2'b10: begin
                if (pending_q == C_MAX) begin
                    w_ovf_set = 1'b1;
                end else begin
                    pending_d = pending_q + C_ONE;
                end
            end
            2'b01:   pending_d = pending_q - C_ONE;
            default: pending_d = pending_q;
        endcase

        valid_d = (pending_d != '0);
        ack_d   = ack_q ^ w_consume;
        // Set has priority over clear
        ovf_d   = w_ovf_set | (ovf_q & ~w_ovf_clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q     <= '0;
            hist_q     <= 1'b0;
            edge_q     <= 1'b0;
            state_q    <= C_ST_INIT;
            init_cnt_q <= 3'd0;
            pending_q  <= '0;
            valid_q    <= 1'b0;
            ack_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], tog_in};
            hist_q     <= w_s;
            edge_q     <= edge_d;
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            pending_q  <= pending_d;
            valid_q    <= valid_d;
            ack_q      <= ack_d;
            ovf_q      <= ovf_d;
        end
    end

    assign ev_valid = valid_q;
    assign ack_tog  = ack_q;
    assign pending  = pending_q;
    assign overflow = ovf_q;

endmodule

`default_nettype wire
